// File: rtl/coordenador_busca_if.sv
// rtl/coordenador_busca_if.sv - coordinator <-> quadrant searcher bus
interface coordenador_busca_if #(
    parameter int tamanhoDistancia = 8
);
    logic                              enable;
    logic [tamanhoDistancia-1:0]       raio;
    logic                              raioAtualizado;
    logic [tamanhoDistancia-1:0]       origemX;
    logic [tamanhoDistancia-1:0]       origemY;
    logic [3:0]                        acabouCalculoLocal;
    logic [3:0]                        operacaoFinalizada;
    logic [3:0][tamanhoDistancia-1:0]  candidatoAtual;
    logic [3:0][tamanhoDistancia-1:0]  coordenadaCandidatoX;
    logic [3:0][tamanhoDistancia-1:0]  coordenadaCandidatoY;

    modport master (
        output enable, raio, raioAtualizado, origemX, origemY,
        input  acabouCalculoLocal, operacaoFinalizada, candidatoAtual,
               coordenadaCandidatoX, coordenadaCandidatoY
    );

    modport slave (
        input  enable, raio, raioAtualizado, origemX, origemY,
        output acabouCalculoLocal, operacaoFinalizada, candidatoAtual,
               coordenadaCandidatoX, coordenadaCandidatoY
    );
endinterface

// File: rtl/coordenador_busca.sv
// rtl/coordenador_busca.sv - expanding-radius search coordinator over four quadrant searchers
module coordenador_busca #(
    parameter int TamanhoMalha     = 20,
    parameter int tamanhoDistancia = 8,
    parameter int RaioMax          = 2*TamanhoMalha,
    parameter int LimiteEspera     = TamanhoMalha*TamanhoMalha+8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [tamanhoDistancia-1:0] posicaoAtualnoEixoX,
    input  logic [tamanhoDistancia-1:0] posicaoAtualnoEixoY,
    coordenador_busca_if.master         busca,
    output logic [tamanhoDistancia-1:0] alvoX,
    output logic [tamanhoDistancia-1:0] alvoY,
    output logic [tamanhoDistancia-1:0] alvoDistancia,
    output logic                        alvoEncontrado,
    output logic                        busy,
    output logic                        done,
    output logic                        erro
);
    localparam int W    = tamanhoDistancia;
    localparam int WD_W = $clog2(LimiteEspera + 1);
    localparam logic [WD_W-1:0] WD_LIM   = WD_W'(LimiteEspera);
    localparam logic [W-1:0]    RAIO_MAX = W'(RaioMax);
    localparam logic [W-1:0]    SEM_CAND = '1;

    typedef enum logic [2:0] {
        IDLE, INICIA, AGUARDA, AVALIA, AVANCA, GUARDA, SELECIONA
    } estado_t;

    estado_t         estado;
    logic [WD_W-1:0] watchdog;
    logic [WD_W-1:0] wd_prox;
    logic            todos_prontos;
    logic            tem_cand;
    logic [1:0]      melhor_idx;
    logic [W-1:0]    melhor_dist;

    assign todos_prontos = &(busca.acabouCalculoLocal | busca.operacaoFinalizada);
    assign wd_prox       = watchdog + 1'b1;

    // Strict '<' keeps the lowest quadrant on ties; all-ones never beats the seed.
    always_comb begin
        tem_cand    = 1'b0;
        melhor_idx  = 2'd0;
        melhor_dist = SEM_CAND;
        for (int q = 0; q < 4; q++) begin
            if (busca.candidatoAtual[q] < melhor_dist) begin
                tem_cand    = 1'b1;
                melhor_idx  = 2'(q);
                melhor_dist = busca.candidatoAtual[q];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado               <= IDLE;
            busca.enable         <= 1'b0;
            busca.raio           <= '0;
            busca.raioAtualizado <= 1'b0;
            busca.origemX        <= '0;
            busca.origemY        <= '0;
            alvoX                <= '0;
            alvoY                <= '0;
            alvoDistancia        <= '0;
            alvoEncontrado       <= 1'b0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            erro                 <= 1'b0;
            watchdog             <= '0;
        end else begin
            done                 <= 1'b0;
            busca.raioAtualizado <= 1'b0;
            case (estado)
                IDLE: begin
                    if (start) begin
                        busca.origemX  <= posicaoAtualnoEixoX;
                        busca.origemY  <= posicaoAtualnoEixoY;
                        busca.raio     <= W'(1);
                        alvoEncontrado <= 1'b0;
                        erro           <= 1'b0;
                        busy           <= 1'b1;
                        estado         <= INICIA;
                    end
                end
                INICIA: begin
                    busca.enable <= 1'b1;
                    watchdog     <= '0;
                    estado       <= AGUARDA;
                end
                AGUARDA: begin
                    if (todos_prontos) begin
                        estado <= AVALIA;
                    end else begin
                        watchdog <= wd_prox;
                        if (wd_prox == WD_LIM) begin
                            erro         <= 1'b1;
                            busca.enable <= 1'b0;
                            estado       <= SELECIONA;
                        end
                    end
                end
                AVALIA: begin
                    if (tem_cand || (&busca.operacaoFinalizada) || busca.raio == RAIO_MAX) begin
                        busca.enable <= 1'b0;
                        estado       <= SELECIONA;
                    end else begin
                        // The new radius and its release pulse appear together in AVANCA.
                        busca.raio           <= busca.raio + 1'b1;
                        busca.raioAtualizado <= 1'b1;
                        estado               <= AVANCA;
                    end
                end
                AVANCA: begin
                    estado <= GUARDA;
                end
                GUARDA: begin
                    watchdog <= '0;
                    estado   <= AGUARDA;
                end
                SELECIONA: begin
                    if (!erro && tem_cand) begin
                        alvoX          <= busca.coordenadaCandidatoX[melhor_idx];
                        alvoY          <= busca.coordenadaCandidatoY[melhor_idx];
                        alvoDistancia  <= melhor_dist;
                        alvoEncontrado <= 1'b1;
                    end else begin
                        alvoEncontrado <= 1'b0;
                    end
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    estado <= IDLE;
                end
                default: estado <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/coordenador_busca.md
COORDENADOR_BUSCA -- requirements
Module: coordenador_busca

Interface
REQ-001 SHALL have parameter TamanhoMalha, default 20, meaning grid side length in cells.
REQ-002 SHALL have parameter tamanhoDistancia, default 8, meaning bit width of coordinates, radius and distances.
REQ-003 SHALL have parameter RaioMax, default 2*TamanhoMalha, meaning largest radius issued before giving up.
REQ-004 SHALL have parameter LimiteEspera, default TamanhoMalha*TamanhoMalha+8, meaning watchdog cycles per radius.
REQ-005 clock  in  1  single system clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to begin a search; ignored unless idle.
REQ-008 posicaoAtualnoEixoX / posicaoAtualnoEixoY  in  tamanhoDistancia each  search origin, sampled on accepted start.
REQ-009 acabouCalculoLocal  in  4  per-quadrant "current radius scanned" flags (bit0 EsquerdaTras, bit1 DireitaTras, bit2 EsquerdaFrente, bit3 DireitaFrente).
REQ-010 operacaoFinalizada  in  4  per-quadrant "quadrant terminated" flags.
REQ-011 candidatoAtual  in  4 x tamanhoDistancia  per-quadrant best distance; all-ones means no candidate.
REQ-012 coordenadaCandidatoX / coordenadaCandidatoY  in  4 x tamanhoDistancia  per-quadrant candidate coordinates.
REQ-013 enable  out  1  drives all four quadrant searchers.
REQ-014 raio  out  tamanhoDistancia  current search radius.
REQ-015 raioAtualizado  out  1  one-cycle pulse that releases the searchers for the next radius.
REQ-016 alvoX / alvoY / alvoDistancia  out  tamanhoDistancia each  selected target.
REQ-017 alvoEncontrado, busy, done, erro  out  1 each  result valid, search active, one-cycle completion pulse, watchdog timeout.

Function
REQ-018 SHALL implement states IDLE, INICIA, AGUARDA, AVALIA, AVANCA, GUARDA, SELECIONA.
REQ-019 IDLE: on start, SHALL latch the origin, set raio=1, clear alvoEncontrado and erro, and go to INICIA; busy=1 in every state except IDLE.
REQ-020 INICIA: SHALL assert enable (held high until SELECIONA), clear the watchdog, and go to AGUARDA next cycle.
REQ-021 AGUARDA: SHALL move to AVALIA in the cycle after (acabouCalculoLocal | operacaoFinalizada) == 4'b1111 is first sampled; this extra cycle lets operacaoFinalizada settle.
REQ-022 AVALIA: SHALL go to SELECIONA if any quadrant has candidatoAtual != all-ones, or operacaoFinalizada == 4'b1111, or raio == RaioMax; otherwise to AVANCA.
REQ-023 AVANCA: SHALL increment raio by 1, assert raioAtualizado for exactly this one cycle, and go to GUARDA.
REQ-024 GUARDA: SHALL last exactly one cycle, ignore acabouCalculoLocal (stale value), reset the watchdog, then go to AGUARDA.
REQ-025 SELECIONA: SHALL select the minimum candidatoAtual among quadrants whose value != all-ones; ties go to the lowest quadrant index.
REQ-026 If a candidate exists, SHALL load alvoX/alvoY/alvoDistancia from that quadrant and set alvoEncontrado=1; otherwise SHALL leave them unchanged and set alvoEncontrado=0.
REQ-027 SELECIONA SHALL deassert enable, pulse done for one cycle, and return to IDLE; results hold until the next accepted start.
REQ-028 Distance comparisons SHALL be unsigned at tamanhoDistancia bits; raio SHALL saturate at RaioMax and never wrap.
REQ-029 Watchdog SHALL count cycles in AGUARDA; on reaching LimiteEspera it SHALL set erro=1, take the SELECIONA path with alvoEncontrado=0, and pulse done.
REQ-030 start asserted outside IDLE SHALL be ignored without affecting the search in progress.
REQ-031 If, at the AVALIA sample, a quadrant reports a candidate while another quadrant is still unfinished, the block SHALL still terminate; a smaller distance at a larger radius is not awaited.

Reset
REQ-032 While reset is high, SHALL force state IDLE, enable=0, raio=0, raioAtualizado=0, alvoX=alvoY=alvoDistancia=0, alvoEncontrado=0, busy=0, done=0, erro=0, watchdog=0, asynchronously and mid-search included.
REQ-033 After reset deasserts, SHALL accept start on the first rising edge.

Verification
REQ-034 Origin (5,5), quadrant 0 reports distance 3 at (3,4) on radius 1, others all-ones -> one AVALIA, no raioAtualizado, alvo=(3,4), alvoDistancia=3, alvoEncontrado=1, done pulse.
REQ-035 No candidates until radius 4, where quadrant 2 reports 7 and quadrant 3 reports 7 -> exactly three raioAtualizado pulses, raio=4, quadrant 2 selected.
REQ-036 All quadrants assert operacaoFinalizada with all-ones candidates at radius 2 -> alvoEncontrado=0, erro=0, done pulse, enable=0.
REQ-037 acabouCalculoLocal stays 4'b0111 -> erro=1 after LimiteEspera cycles, done pulse, returns to IDLE.
REQ-038 reset pulsed during AGUARDA at radius 3 -> all outputs zero immediately, next start restarts at raio=1.
REQ-039 start re-pulsed during AGUARDA -> no effect on raio, origin or outputs.
